foobar_gen: RTL and testbench

FOOBAR_GEN -- requirements
Module: foobar_gen

---
 rtl/foobar_gen.sv | 163 ++++++++++++++++
 tb/tb_foobar_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/foobar_gen.sv
// Periodic foo/bar pulse generator with pulse counters, wrap flags and a
// ready/valid configuration port that is only open while the block is idle.
module foobar_gen #(
    parameter int unsigned DEF_FOO_PERIOD = 3,
    parameter int unsigned DEF_BAR_PERIOD = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_foo_period,
    input  logic [7:0] cfg_bar_period,
    output logic       cfg_ready,
    output logic       cfg_err,
    output logic       foo,
    output logic       bar,
    output logic [7:0] count_foo,
    output logic [7:0] count_bar,
    output logic       foo_wrap,
    output logic       bar_wrap
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] DEF_FOO = 8'(DEF_FOO_PERIOD);
    localparam logic [7:0] DEF_BAR = 8'(DEF_BAR_PERIOD);

    state_t     state_q, state_d;
    logic       cfg_ready_q, cfg_ready_d;
    logic       cfg_err_q, cfg_err_d;
    logic [7:0] foo_per_q, foo_per_d;
    logic [7:0] bar_per_q, bar_per_d;
    logic [7:0] foo_ph_q, foo_ph_d;
    logic [7:0] bar_ph_q, bar_ph_d;
    logic [7:0] count_foo_q, count_foo_d;
    logic [7:0] count_bar_q, count_bar_d;
    logic       foo_q, foo_d;
    logic       bar_q, bar_d;
    logic       foo_wrap_q, foo_wrap_d;
    logic       bar_wrap_q, bar_wrap_d;

    logic       hs_s;
    logic       cfg_ok_s;

    assign hs_s     = cfg_valid & cfg_ready_q;
    assign cfg_ok_s = (cfg_foo_period != 8'd0) && (cfg_bar_period != 8'd0);

    // Next-state, configuration and pulse generation
    always_comb begin
        state_d     = state_q;
        foo_per_d   = foo_per_q;
        bar_per_d   = bar_per_q;
        foo_ph_d    = foo_ph_q;
        bar_ph_d    = bar_ph_q;
        count_foo_d = count_foo_q;
        count_bar_d = count_bar_q;
        foo_d       = 1'b0;
        bar_d       = 1'b0;
        foo_wrap_d  = 1'b0;
        bar_wrap_d  = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && !hs_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake edge never counts, even with en high
        if (hs_s) begin
            if (cfg_ok_s) begin
                foo_per_d   = cfg_foo_period;
                bar_per_d   = cfg_bar_period;
                foo_ph_d    = 8'd0;
                bar_ph_d    = 8'd0;
                count_foo_d = 8'd0;
                count_bar_d = 8'd0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (en) begin
            if (foo_ph_q >= foo_per_q - 8'd1) begin
                foo_ph_d    = 8'd0;
                foo_d       = 1'b1;
                count_foo_d = count_foo_q + 8'd1;
                foo_wrap_d  = (count_foo_q == 8'd255);
            end else begin
                foo_ph_d = foo_ph_q + 8'd1;
            end
            if (bar_ph_q >= bar_per_q - 8'd1) begin
                bar_ph_d    = 8'd0;
                bar_d       = 1'b1;
                count_bar_d = count_bar_q + 8'd1;
                bar_wrap_d  = (count_bar_q == 8'd255);
            end else begin
                bar_ph_d = bar_ph_q + 8'd1;
            end
        end else begin
            foo_ph_d = foo_ph_q;
            bar_ph_d = bar_ph_q;
        end

        cfg_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            foo_per_q   <= DEF_FOO;
            bar_per_q   <= DEF_BAR;
            foo_ph_q    <= 8'd0;
            bar_ph_q    <= 8'd0;
            count_foo_q <= 8'd0;
            count_bar_q <= 8'd0;
            foo_q       <= 1'b0;
            bar_q       <= 1'b0;
            foo_wrap_q  <= 1'b0;
            bar_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            foo_per_q   <= foo_per_d;
            bar_per_q   <= bar_per_d;
            foo_ph_q    <= foo_ph_d;
            bar_ph_q    <= bar_ph_d;
            count_foo_q <= count_foo_d;
            count_bar_q <= count_bar_d;
            foo_q       <= foo_d;
            bar_q       <= bar_d;
            foo_wrap_q  <= foo_wrap_d;
            bar_wrap_q  <= bar_wrap_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign foo       = foo_q;
    assign bar       = bar_q;
    assign count_foo = count_foo_q;
    assign count_bar = count_bar_q;
    assign foo_wrap  = foo_wrap_q;
    assign bar_wrap  = bar_wrap_q;

endmodule

// File: tb/tb_foobar_gen.sv
// Directed self-checking bench for foobar_gen; inputs change 1 time unit after
// each rising edge and outputs are sampled at that same point.
module tb_foobar_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_foo_period;
    logic [7:0] cfg_bar_period;
    logic       cfg_ready;
    logic       cfg_err;
    logic       foo;
    logic       bar;
    logic [7:0] count_foo;
    logic [7:0] count_bar;
    logic       foo_wrap;
    logic       bar_wrap;

    int n_pass;
    int n_total;

    foobar_gen #(.DEF_FOO_PERIOD(3), .DEF_BAR_PERIOD(5)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid),
        .cfg_foo_period(cfg_foo_period), .cfg_bar_period(cfg_bar_period),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .foo(foo), .bar(bar),
        .count_foo(count_foo), .count_bar(count_bar),
        .foo_wrap(foo_wrap), .bar_wrap(bar_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        cfg_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_foo_period = 8'd0; cfg_bar_period = 8'd0;
        #3;
        n_total++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_ready); else n_pass++;
        n_total++; if ({foo, bar, foo_wrap, bar_wrap, cfg_err} !== 5'b0) $display("FAIL reset_pulses: got %b want 00000", {foo, bar, foo_wrap, bar_wrap, cfg_err}); else n_pass++;
        n_total++; if ({count_foo, count_bar} !== 16'h0) $display("FAIL reset_counts: got %h want 0000", {count_foo, count_bar}); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_defaults();
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            n_total++; if (foo !== ((e % 3) == 0)) $display("FAIL def_foo e%0d: got %b want %b", e, foo, (e % 3) == 0); else n_pass++;
            n_total++; if (bar !== ((e % 5) == 0)) $display("FAIL def_bar e%0d: got %b want %b", e, bar, (e % 5) == 0); else n_pass++;
            n_total++; if (count_foo !== 8'(e / 3)) $display("FAIL def_cfoo e%0d: got %0d want %0d", e, count_foo, e / 3); else n_pass++;
            n_total++; if (count_bar !== 8'(e / 5)) $display("FAIL def_cbar e%0d: got %0d want %0d", e, count_bar, e / 5); else n_pass++;
            n_total++; if (cfg_ready !== 1'b0) $display("FAIL def_ready e%0d: got %b want 0", e, cfg_ready); else n_pass++;
        end
    endtask

    task automatic test_cfg_ok();
        do_reset();
        en = 1'b1; cfg_valid = 1'b1;
        cfg_foo_period = 8'd2; cfg_bar_period = 8'd7;
        step();
        cfg_valid = 1'b0;
        n_total++; if (cfg_ready !== 1'b1) $display("FAIL cfg_stay_idle: got %b want 1", cfg_ready); else n_pass++;
        n_total++; if ({foo, bar, cfg_err} !== 3'b0) $display("FAIL cfg_hs_pulse: got %b want 000", {foo, bar, cfg_err}); else n_pass++;
        n_total++; if ({count_foo, count_bar} !== 16'h0) $display("FAIL cfg_hs_counts: got %h want 0000", {count_foo, count_bar}); else n_pass++;
        for (int e = 1; e <= 14; e++) begin
            step();
            n_total++; if (foo !== ((e % 2) == 0)) $display("FAIL cfg_foo e%0d: got %b want %b", e, foo, (e % 2) == 0); else n_pass++;
            n_total++; if (bar !== ((e % 7) == 0)) $display("FAIL cfg_bar e%0d: got %b want %b", e, bar, (e % 7) == 0); else n_pass++;
        end
        n_total++; if (count_foo !== 8'd7) $display("FAIL cfg_cfoo: got %0d want 7", count_foo); else n_pass++;
        n_total++; if (count_bar !== 8'd2) $display("FAIL cfg_cbar: got %0d want 2", count_bar); else n_pass++;
    endtask

    task automatic test_cfg_err();
        do_reset();
        en = 1'b1;
        repeat (4) step();
        en = 1'b0;
        step();
        n_total++; if (cfg_ready !== 1'b1) $display("FAIL err_ready: got %b want 1", cfg_ready); else n_pass++;
        cfg_valid = 1'b1; cfg_foo_period = 8'd0; cfg_bar_period = 8'd4;
        step();
        cfg_valid = 1'b0;
        n_total++; if (cfg_err !== 1'b1) $display("FAIL err_pulse: got %b want 1", cfg_err); else n_pass++;
        n_total++; if (count_foo !== 8'd1) $display("FAIL err_cfoo: got %0d want 1", count_foo); else n_pass++;
        step();
        n_total++; if (cfg_err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", cfg_err); else n_pass++;
        en = 1'b1;
        step();
        n_total++; if ({foo, bar} !== 2'b01) $display("FAIL err_keep_bar: got foo,bar=%b want 01", {foo, bar}); else n_pass++;
        step();
        n_total++; if ({foo, bar} !== 2'b10) $display("FAIL err_keep_foo: got foo,bar=%b want 10", {foo, bar}); else n_pass++;
        n_total++; if (count_foo !== 8'd2) $display("FAIL err_cfoo2: got %0d want 2", count_foo); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        cfg_valid = 1'b1; cfg_foo_period = 8'd1; cfg_bar_period = 8'd255;
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        for (int e = 1; e <= 256; e++) begin
            step();
            n_total++; if (foo !== 1'b1) $display("FAIL wrap_foo e%0d: got %b want 1", e, foo); else n_pass++;
            if (e == 254) begin
                n_total++; if (bar !== 1'b0) $display("FAIL wrap_bar254: got %b want 0", bar); else n_pass++;
            end
            if (e == 255) begin
                n_total++; if (bar !== 1'b1) $display("FAIL wrap_bar255: got %b want 1", bar); else n_pass++;
                n_total++; if (count_foo !== 8'd255) $display("FAIL wrap_cfoo255: got %0d want 255", count_foo); else n_pass++;
                n_total++; if (foo_wrap !== 1'b0) $display("FAIL wrap_early: got %b want 0", foo_wrap); else n_pass++;
            end
        end
        n_total++; if (count_foo !== 8'd0) $display("FAIL wrap_cfoo: got %0d want 0", count_foo); else n_pass++;
        n_total++; if (foo_wrap !== 1'b1) $display("FAIL wrap_flag: got %b want 1", foo_wrap); else n_pass++;
        n_total++; if (count_bar !== 8'd1) $display("FAIL wrap_cbar: got %0d want 1", count_bar); else n_pass++;
        n_total++; if ({bar, bar_wrap} !== 2'b00) $display("FAIL wrap_bar256: got %b want 00", {bar, bar_wrap}); else n_pass++;
        step();
        n_total++; if (foo_wrap !== 1'b0) $display("FAIL wrap_one_cycle: got %b want 0", foo_wrap); else n_pass++;
    endtask

    task automatic test_pause();
        do_reset();
        en = 1'b1;
        repeat (2) step();
        n_total++; if (cfg_ready !== 1'b0) $display("FAIL pause_ready_run: got %b want 0", cfg_ready); else n_pass++;
        en = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            n_total++; if (cfg_ready !== 1'b1) $display("FAIL pause_ready e%0d: got %b want 1", e, cfg_ready); else n_pass++;
            n_total++; if (foo !== 1'b0) $display("FAIL pause_foo e%0d: got %b want 0", e, foo); else n_pass++;
        end
        en = 1'b1;
        step();
        n_total++; if (foo !== 1'b1) $display("FAIL pause_resume_foo: got %b want 1", foo); else n_pass++;
        n_total++; if (count_foo !== 8'd1) $display("FAIL pause_cfoo: got %0d want 1", count_foo); else n_pass++;
        n_total++; if (cfg_ready !== 1'b0) $display("FAIL pause_ready_after: got %b want 0", cfg_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        repeat (4) step();
        n_total++; if (count_foo !== 8'd1) $display("FAIL mid_pre_cfoo: got %0d want 1", count_foo); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (count_foo !== 8'd0) $display("FAIL mid_async_cfoo: got %0d want 0", count_foo); else n_pass++;
        n_total++; if (cfg_ready !== 1'b1) $display("FAIL mid_async_ready: got %b want 1", cfg_ready); else n_pass++;
        #2;
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            n_total++; if (foo !== (e == 3)) $display("FAIL mid_foo e%0d: got %b want %b", e, foo, e == 3); else n_pass++;
        end
        n_total++; if (count_foo !== 8'd1) $display("FAIL mid_cfoo: got %0d want 1", count_foo); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_defaults();
        test_cfg_ok();
        test_cfg_err();
        test_wrap();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
